pe3_stage_ctrl: RTL and testbench
=================================

# pe3_stage_ctrl

Sequencer for one radix-2 NTT layer on the 512-point constant-twiddle butterfly PE (PE3). On a start pulse it walks all 256 butterfly pairs of the selected stage, issuing paired read addresses to the coefficient memory. It delays those addresses through a valid-tagged pipeline matched to memory-read plus PE latency, then issues paired write-back addresses and a done pulse. It sits between the top-level NTT scheduler and the PE3/coefficient-memory datapath.

## Interface

Parameters:
- N, 512, transform length (power of two)
- LOGN, 9, log2(N)
- ADDR_W, 9, coefficient address width
- RD_LAT, 1, synchronous memory read latency in cycles
- PE_LAT, 6, PE3 latency from u/v input to bf_upper/bf_lower

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  one-cycle request to run a stage
- stage  in  4  stage index, sampled with start; valid 0..LOGN-1
- sel_ntt_in  in  1  mode bit, sampled with start
- busy  out  1  stage in progress
- done  out  1  one-cycle pulse after the last write
- err  out  1  one-cycle pulse when a start is rejected
- rd_en  out  1  read strobe to coefficient memory
- rd_addr_u, rd_addr_v  out  ADDR_W  read addresses for the pair
- wr_en  out  1  write strobe
- wr_addr_u, wr_addr_v  out  ADDR_W  write-back addresses
- sel_ntt  out  1  held copy of sel_ntt_in for PE3 for the whole run

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If start and stage<LOGN: latch stage and sel_ntt, clear k, go to ISSUE.
  - If start and stage>=LOGN: pulse err and stay in IDLE.
- start is ignored outside IDLE: no err, no effect.
- ISSUE:
  - rd_en=1 every cycle for pair index k=0..N/2-1.
  - j = k & ((1<<stage)-1).
  - rd_addr_u = ((k>>stage)<<(stage+1)) | j.
  - rd_addr_v = rd_addr_u + (1<<stage).
  - After k=N/2-1, go to DRAIN.
- DRAIN: rd_en=0. Wait until the delay line holds no valid entries, then go to DONE.
- DONE: pulse done for one cycle, go to IDLE.
- Delay line: depth RD_LAT+PE_LAT. Each entry is {valid, addr_u, addr_v}, shifted every cycle with no stall. The tail drives wr_en/wr_addr_u/wr_addr_v.
- Write mapping (datapath contract): bf_lower (u+w·v) is written to wr_addr_u; bf_upper (u−w·v) is written to wr_addr_v.
- Address arithmetic is unsigned ADDR_W-bit. rd_addr_v never exceeds N-1 for legal stage values; no wrap is required.
- Stage 0: pairs (0,1),(2,3)…. Stage 8: pairs (k, k+256).
- Reset (any state, including mid-run):
  - All outputs go to 0 on the next edge and the FSM goes to IDLE.
  - All delay-line valid bits are cleared, so no wr_en is issued for in-flight reads.

## Timing

- Reset values: busy=0, done=0, err=0, rd_en=0, wr_en=0, all addresses=0, sel_ntt=0.
- Cycle 0: start is sampled. Cycles 1..256: rd_en high. busy goes high at cycle 1.
- LAT = RD_LAT+PE_LAT = 7. Every wr_en appears exactly LAT cycles after its rd_en: cycles 8..263 with default parameters.
- busy stays high through cycle 263 and is low at cycle 264. done is high at cycle 264 only.
- A new start is accepted at cycle 265 at the earliest, so back-to-back stages are 265 cycles apart.
- err is asserted in the cycle after the rejected start.
- wr_en and rd_en overlap during cycles 8..256; the memory must support one read and one write pair per cycle.

## Structure

- Shared package ntt_pkg holds:
  - N, LOGN, ADDR_W
  - RD_LAT, PE_LAT and derived WB_LAT
  - the FSM state enumeration (IDLE, ISSUE, DRAIN, DONE)
- One sub-module, addr_delay_line: a parameterised depth × (1+2·ADDR_W) shift register with synchronous active-low reset that clears valid bits only.
- The FSM, pair counter and address generator stay in pe3_stage_ctrl.

## Test plan

- Reset then start with stage=0 → rd pairs (0,1),(2,3)…(510,511) on cycles 1..256; wr pairs identical on cycles 8..263; done at 264; exactly 256 wr_en.
- start with stage=8 → first rd pair (0,256), last rd pair (255,511); done at cycle 264.
- start with stage=3, k=9 → rd_addr_u=17, rd_addr_v=25 on cycle 10, and the same pair on the write port at cycle 17.
- start with stage=9 and again with stage=15 → err pulse, busy stays 0, no rd_en.
- Second start at cycle 100 of a run → ignored, no err; first done still at 264; a start at cycle 265 begins a new run.
- rst low at cycle 50 → all outputs 0 from cycle 51; no wr_en afterwards; a fresh start then runs a full 256-pair stage.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants for the PE3 NTT datapath: transform geometry, write-back latency
// and the stage-sequencer state encoding.
package ntt_pkg;

  localparam int N      = 512;
  localparam int LOGN   = 9;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 1;
  localparam int PE_LAT = 6;
  localparam int WB_LAT = RD_LAT + PE_LAT;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/pe3_stage_ctrl_if.sv
// Scheduler-facing control and memory-facing address bus of the PE3 stage sequencer.
// The master side is the NTT scheduler / memory; the slave side is pe3_stage_ctrl.
interface pe3_stage_ctrl_if #(
  parameter int ADDR_W = ntt_pkg::ADDR_W
) ();

  logic              start;
  logic [3:0]        stage;
  logic              sel_ntt_in;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_u;
  logic [ADDR_W-1:0] rd_addr_v;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_u;
  logic [ADDR_W-1:0] wr_addr_v;
  logic              sel_ntt;

  modport master (
    output start, stage, sel_ntt_in,
    input  busy, done, err, rd_en, rd_addr_u, rd_addr_v,
    input  wr_en, wr_addr_u, wr_addr_v, sel_ntt
  );

  modport slave (
    input  start, stage, sel_ntt_in,
    output busy, done, err, rd_en, rd_addr_u, rd_addr_v,
    output wr_en, wr_addr_u, wr_addr_v, sel_ntt
  );

endinterface

// File: rtl/addr_delay_line.sv
// Fixed-depth, no-stall shift register carrying {valid, addr_u, addr_v} from the
// read issue point to the write-back point; reset clears only the valid bits.
module addr_delay_line #(
  parameter int DEPTH  = ntt_pkg::WB_LAT,
  parameter int ADDR_W = ntt_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr_u,
  input  logic [ADDR_W-1:0] in_addr_v,
  output logic [DEPTH-1:0]  valid_vec,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr_u,
  output logic [ADDR_W-1:0] out_addr_v
);

  logic [DEPTH-1:0]    valid_q;
  logic [ADDR_W-1:0]   u_q [DEPTH];
  logic [ADDR_W-1:0]   v_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift is order independent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: the address payload is deliberately not reset; it is only meaningful
  // when its valid bit is set, and leaving it unreset keeps it a plain register array.
  always_ff @(posedge clk) begin
    u_q[0] <= in_addr_u;
    v_q[0] <= in_addr_v;
    for (int i = 1; i < DEPTH; i++) begin
      u_q[i] <= u_q[i-1];
      v_q[i] <= v_q[i-1];
    end
  end

  assign valid_vec  = valid_q;
  assign out_valid  = valid_q[DEPTH-1];
  assign out_addr_u = u_q[DEPTH-1];
  assign out_addr_v = v_q[DEPTH-1];

endmodule

// File: rtl/pe3_stage_ctrl.sv
// Sequencer for one radix-2 NTT layer on PE3: walks the N/2 butterfly pairs of a
// stage, issues paired reads, and replays the addresses as write-backs after LAT cycles.
module pe3_stage_ctrl #(
  parameter int N      = ntt_pkg::N,
  parameter int LOGN   = ntt_pkg::LOGN,
  parameter int ADDR_W = ntt_pkg::ADDR_W,
  parameter int RD_LAT = ntt_pkg::RD_LAT,
  parameter int PE_LAT = ntt_pkg::PE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  pe3_stage_ctrl_if.slave    bus
);

  import ntt_pkg::IDLE;
  import ntt_pkg::ISSUE;
  import ntt_pkg::DRAIN;
  import ntt_pkg::DONE;

  localparam int                KW        = LOGN - 1;
  localparam int                DEPTH     = RD_LAT + PE_LAT;
  localparam logic [KW-1:0]     K_LAST    = KW'(N / 2 - 1);
  localparam logic [3:0]        STAGE_LIM = 4'(LOGN);
  localparam logic [DEPTH-1:0]  TAIL_MASK = DEPTH'(1) << (DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [1:0]        state;
  logic [KW-1:0]     k;
  logic [3:0]        stage_q;
  logic              sel_q;
  logic              err_q;

  logic [ADDR_W-1:0] kx;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] addr_u;
  logic [ADDR_W-1:0] addr_v;

  logic [DEPTH-1:0]  dl_valid;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_u;
  logic [ADDR_W-1:0] wb_v;

  logic              issuing;
  logic              drain_clear;

  assign issuing = (state == ISSUE);

  // Leaving DRAIN when only the tail entry is still valid lets that last write
  // retire in the same cycle the FSM moves on, so done follows it immediately.
  assign drain_clear = (dl_valid & ~TAIL_MASK) == '0;

  // NOTE: every signal of this block is assigned on every pass, so it stays
  // purely combinational and no latch is inferred.
  always_comb begin
    kx     = ADDR_W'(k);
    span   = ONE << stage_q;
    addr_u = ((kx >> stage_q) << (stage_q + 4'd1)) | (kx & (span - ONE));
    addr_v = addr_u + span;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      stage_q <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.stage < STAGE_LIM) begin
              state   <= ISSUE;
              stage_q <= bus.stage;
              sel_q   <= bus.sel_ntt_in;
              k       <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= DRAIN;
        end
        DRAIN:   if (drain_clear) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  addr_delay_line #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (issuing),
    .in_addr_u  (addr_u),
    .in_addr_v  (addr_v),
    .valid_vec  (dl_valid),
    .out_valid  (wb_valid),
    .out_addr_u (wb_u),
    .out_addr_v (wb_v)
  );

  assign bus.busy      = (state == ISSUE) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;
  assign bus.sel_ntt   = sel_q;

  assign bus.rd_en     = issuing;
  assign bus.rd_addr_u = issuing ? addr_u : '0;
  assign bus.rd_addr_v = issuing ? addr_v : '0;

  // The datapath writes bf_lower (u+w*v) to wr_addr_u and bf_upper (u-w*v) to wr_addr_v.
  assign bus.wr_en     = wb_valid;
  assign bus.wr_addr_u = wb_valid ? wb_u : '0;
  assign bus.wr_addr_v = wb_valid ? wb_v : '0;

endmodule

// File: tb/tb_pe3_stage_ctrl.sv
// Scoreboard bench for pe3_stage_ctrl: stimulus queues expected read/write pairs and
// done/err pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_pe3_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe3_stage_ctrl_if bus ();

  pe3_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int u;
    int v;
  } pair_ev_t;

  pair_ev_t rd_q[$];
  pair_ev_t wr_q[$];
  int       done_q[$];
  int       err_q[$];

  int       n_checks = 0;
  int       n_fail   = 0;
  int       n_wr     = 0;
  bit       mon_en   = 1'b0;
  pair_ev_t mon_e;
  int       mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  // Lower index of butterfly pair k in a stage with half-span 2**s.
  function automatic int model_u(input int k, input int s);
    int span;
    span = 1 << s;
    return (k / span) * (2 * span) + (k % span);
  endfunction

  // Expectations for a run whose start is held during absolute cycle t0.
  task automatic expect_run(input int t0, input int s);
    int u;
    for (int k = 0; k < 256; k++) begin
      u = model_u(k, s);
      rd_q.push_back('{t0 + 1 + k, u, u + (1 << s)});
      wr_q.push_back('{t0 + 8 + k, u, u + (1 << s)});
    end
    done_q.push_back(t0 + 264);
  endtask

  task automatic flush_after(input int lim);
    while (rd_q.size() > 0 && rd_q[$].cyc > lim) void'(rd_q.pop_back());
    while (wr_q.size() > 0 && wr_q[$].cyc > lim) void'(wr_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > lim) void'(done_q.pop_back());
  endtask

  task automatic pulse_start(input logic [3:0] s, input logic m);
    bus.start      = 1'b1;
    bus.stage      = s;
    bus.sel_ntt_in = m;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.stage      = 4'd0;
    bus.sel_ntt_in = 1'b0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_err"},       32'(bus.err),       0);
    check({tag, "_rd_en"},     32'(bus.rd_en),     0);
    check({tag, "_wr_en"},     32'(bus.wr_en),     0);
    check({tag, "_rd_addr_u"}, 32'(bus.rd_addr_u), 0);
    check({tag, "_rd_addr_v"}, 32'(bus.rd_addr_v), 0);
    check({tag, "_wr_addr_u"}, 32'(bus.wr_addr_u), 0);
    check({tag, "_wr_addr_v"}, 32'(bus.wr_addr_v), 0);
    check({tag, "_sel_ntt"},   32'(bus.sel_ntt),   0);
  endtask

  // Monitor: every strobe seen must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_en === 1'b1) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_e = rd_q.pop_front();
          check("rd_cycle",  cyc, mon_e.cyc);
          check("rd_addr_u", 32'(bus.rd_addr_u), mon_e.u);
          check("rd_addr_v", 32'(bus.rd_addr_v), mon_e.v);
        end
      end
      if (bus.wr_en === 1'b1) begin
        n_wr++;
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_e = wr_q.pop_front();
          check("wr_cycle",  cyc, mon_e.cyc);
          check("wr_addr_u", 32'(bus.wr_addr_u), mon_e.u);
          check("wr_addr_v", 32'(bus.wr_addr_v), mon_e.v);
        end
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_c = done_q.pop_front();
          check("done_cycle", cyc, mon_c);
        end
      end
      if (bus.err === 1'b1) begin
        if (err_q.size() == 0) check("err_unexpected", 1, 0);
        else begin
          mon_c = err_q.pop_front();
          check("err_cycle", cyc, mon_c);
        end
      end
    end
  end

  initial begin
    int t0;
    int wr0;

    bus.start      = 1'b0;
    bus.stage      = 4'd0;
    bus.sel_ntt_in = 1'b0;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Stage 0, NTT mode: pairs (0,1)..(510,511).
    t0  = cyc;
    wr0 = n_wr;
    expect_run(t0, 0);
    pulse_start(4'd0, 1'b1);
    check("a_busy_c1",   32'(bus.busy),      1);
    check("a_sel_ntt",   32'(bus.sel_ntt),   1);
    check("a_rd_u_c1",   32'(bus.rd_addr_u), 0);
    check("a_rd_v_c1",   32'(bus.rd_addr_v), 1);
    goto(t0 + 256);
    check("a_rd_u_c256", 32'(bus.rd_addr_u), 510);
    check("a_rd_v_c256", 32'(bus.rd_addr_v), 511);
    goto(t0 + 263);
    check("a_busy_c263", 32'(bus.busy),      1);
    goto(t0 + 264);
    check("a_busy_c264", 32'(bus.busy),      0);
    check("a_done_c264", 32'(bus.done),      1);
    goto(t0 + 265);
    check("a_wr_count",  n_wr - wr0,         256);

    // Stage 8 back-to-back, with a stray start at cycle 100 that must be ignored.
    t0 = cyc;
    expect_run(t0, 8);
    pulse_start(4'd8, 1'b0);
    check("b_rd_u_c1",   32'(bus.rd_addr_u), 0);
    check("b_rd_v_c1",   32'(bus.rd_addr_v), 256);
    check("b_sel_ntt",   32'(bus.sel_ntt),   0);
    goto(t0 + 100);
    pulse_start(4'd2, 1'b1);
    check("b_ignored_err", 32'(bus.err),     0);
    check("b_ignored_sel", 32'(bus.sel_ntt), 0);
    goto(t0 + 256);
    check("b_rd_u_c256", 32'(bus.rd_addr_u), 255);
    check("b_rd_v_c256", 32'(bus.rd_addr_v), 511);
    goto(t0 + 265);

    // Stage 3: k=9 gives pair (17,25) on read cycle 10 and write cycle 17.
    t0 = cyc;
    expect_run(t0, 3);
    pulse_start(4'd3, 1'b0);
    goto(t0 + 10);
    check("c_rd_u_k9",   32'(bus.rd_addr_u), 17);
    check("c_rd_v_k9",   32'(bus.rd_addr_v), 25);
    goto(t0 + 17);
    check("c_wr_en_k9",  32'(bus.wr_en),     1);
    check("c_wr_u_k9",   32'(bus.wr_addr_u), 17);
    check("c_wr_v_k9",   32'(bus.wr_addr_v), 25);
    goto(t0 + 266);

    // Illegal stages 9 and 15: err pulse only.
    t0 = cyc;
    err_q.push_back(t0 + 1);
    pulse_start(4'd9, 1'b1);
    check("e9_busy",     32'(bus.busy),      0);
    check("e9_rd_en",    32'(bus.rd_en),     0);
    check("e9_sel_ntt",  32'(bus.sel_ntt),   0);
    @(negedge clk);
    check("e9_err_gone", 32'(bus.err),       0);
    t0 = cyc;
    err_q.push_back(t0 + 1);
    pulse_start(4'd15, 1'b0);
    check("e15_busy",    32'(bus.busy),      0);
    check("e15_rd_en",   32'(bus.rd_en),     0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a stage-5 run.
    t0 = cyc;
    expect_run(t0, 5);
    pulse_start(4'd5, 1'b1);
    goto(t0 + 50);
    rst = 1'b0;
    flush_after(t0 + 50);
    @(negedge clk);
    check_quiet("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_busy_after", 32'(bus.busy), 0);

    // Fresh full run after the reset.
    t0  = cyc;
    wr0 = n_wr;
    expect_run(t0, 1);
    pulse_start(4'd1, 1'b0);
    goto(t0 + 265);
    check("f_wr_count",  n_wr - wr0,         256);

    check("rd_q_empty",   rd_q.size(),   0);
    check("wr_q_empty",   wr_q.size(),   0);
    check("done_q_empty", done_q.size(), 0);
    check("err_q_empty",  err_q.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
